output_argmax: RTL and testbench
================================

Name: output_argmax

Overview:
- Classification stage directly downstream of the output-layer neurons.
- Accepts one 8-bit signed neuron score per handshake, for NUM_CLASSES scores per inference.
- Tracks the running maximum and emits the winning class index plus its score through a valid/ready output.
- Sits between the output-layer neuron bank (serialised by the layer controller) and the result register/UART reporter.

Parameters:
- NUM_CLASSES, 10, number of scores per inference; legal range 2..256.
- DATA_W, 8, score width, two's-complement signed.
- IDX_W, 4, class index width; must satisfy 2^IDX_W >= NUM_CLASSES.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  asynchronous active-high reset.
- start  input  1  one-cycle pulse that begins an inference; honoured only in IDLE.
- in_valid  input  1  upstream score valid.
- in_ready  output  1  block can accept a score this cycle.
- in_val  input  DATA_W  signed neuron score (out_val of an output neuron).
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- class_idx  output  IDX_W  index (0-based, arrival order) of the maximum score.
- max_val  output  DATA_W  signed maximum score.
- busy  output  1  high in COLLECT or DONE.

Behaviour:
- Reset (async, rst=1): state=IDLE. in_ready=0, out_valid=0, busy=0, class_idx=0, max_val=0, internal count=0. Takes effect immediately and mid-inference; any partial inference is discarded.
- States: IDLE, COLLECT, DONE.
- IDLE:
  - in_ready=0.
  - start=1 -> COLLECT next cycle; count cleared to 0.
  - in_valid is ignored.
- COLLECT:
  - in_ready=1.
  - Accept occurs when in_valid and in_ready are both 1.
  - On accept with count==0: max_val<=in_val, class_idx<=0.
  - On accept with count>0: if $signed(in_val) > $signed(max_val), then max_val<=in_val and class_idx<=count; otherwise hold.
  - count increments on each accept.
  - On the accept where count==NUM_CLASSES-1 -> DONE next cycle.
  - No accept -> hold state and registers; bubbles of any length are allowed.
- DONE:
  - in_ready=0, out_valid=1.
  - class_idx and max_val are stable while out_valid=1.
  - out_valid and out_ready both 1 -> IDLE next cycle, out_valid=0.
  - Outputs retain their last values in IDLE until the next accept.
- Comparison is strictly greater-than, signed. On ties the lowest index wins.
- Latency: out_valid rises the cycle after the final score is accepted. Minimum inference is 1 (start) + NUM_CLASSES + 1 cycles.
- start outside IDLE is ignored (no restart, no error).
- start in the same cycle as the DONE->IDLE handshake is ignored; start must be reasserted in IDLE.
- in_valid with in_ready=0 is neither consumed nor counted.
- busy = (state != IDLE).
- No arithmetic overflow is possible: compare only, no accumulation. count is IDX_W+1 bits wide internally, so NUM_CLASSES=2^IDX_W never wraps.

Test Plan:
- Basic: reset, start, scores 5,-3,12,7,0,1,2,3,4,6 back-to-back -> out_valid one cycle after 10th accept; class_idx=2, max_val=12; busy=1 throughout.
- Signed/ties: scores -128,-5,-5,-100,-128,-6,-7,-9,-10,-20 -> class_idx=1, max_val=-5 (0xFB); -128 must never win over -5.
- Last/first position: all 0x00 except index 9 = 127 -> class_idx=9; separate run with index 0 = 127 and the rest 126 -> class_idx=0.
- Handshake stress:
  - Random in_valid bubbles: the same 10 scores as Basic must still give class_idx=2.
  - out_ready held low 20 cycles: out_valid stays 1 with outputs stable.
  - in_valid during DONE: not accepted (in_ready=0).
  - A second inference after handshake is independent of the first.
- Reset and start misuse:
  - Assert rst asynchronously after 4 accepts: outputs zero immediately and state returns to IDLE.
  - New start then 10 scores gives the correct fresh result.
  - start pulses during COLLECT and DONE have no effect on count or result.

Source files
------------

// File: rtl/output_argmax.sv
// output_argmax: picks the winning class from a serial stream of signed output-neuron scores.
// Latency: out_valid rises the cycle after the final score is accepted (1 start + NUM_CLASSES + 1 cycles minimum).
// Backpressure: in_ready is high only while collecting; the result is held stable in DONE until out_ready.
//
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   start               one-cycle pulse that opens an inference (only honoured in IDLE)
//   in_valid/in_ready   score handshake; in_val is a two's-complement score
//   out_valid/out_ready result handshake; class_idx/max_val hold the winner
//   busy                high while an inference is collecting or waiting to be taken
module output_argmax #(
  parameter int NUM_CLASSES = 10,
  parameter int DATA_W      = 8,
  parameter int IDX_W       = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_val,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [IDX_W-1:0]  class_idx,
  output logic [DATA_W-1:0] max_val,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } state_t;

  // One extra bit so NUM_CLASSES == 2**IDX_W can be counted without wrapping.
  localparam logic [IDX_W:0] LAST = (IDX_W+1)'(NUM_CLASSES - 1);

  state_t         state;
  logic [IDX_W:0] count;
  logic           better;

  // The first score of an inference always seeds the maximum; after that only a
  // strictly greater score replaces it, so ties keep the lowest index.
  assign better = (count == '0) || ($signed(in_val) > $signed(max_val));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      count     <= '0;
      class_idx <= '0;
      max_val   <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state    <= COLLECT;
            count    <= '0;
            in_ready <= 1'b1;
            busy     <= 1'b1;
          end
        end

        COLLECT: begin
          // in_ready is known to be high here, so in_valid alone means accept.
          if (in_valid) begin
            if (better) begin
              max_val   <= in_val;
              class_idx <= count[IDX_W-1:0];
            end
            count <= count + 1'b1;
            if (count == LAST) begin
              state     <= DONE;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
            end
          end
        end

        DONE: begin
          // A start arriving with the handshake is dropped: we only look at
          // start while already in IDLE.
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end

        default: begin
          state     <= IDLE;
          in_ready  <= 1'b0;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_output_argmax.sv
module tb_output_argmax;
  localparam int NC = 10;
  localparam int DW = 8;
  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_val;
  logic          out_valid;
  logic          out_ready;
  logic [IW-1:0] class_idx;
  logic [DW-1:0] max_val;
  logic          busy;

  int vectors     = 0;
  int miscompares = 0;

  logic [DW-1:0] sc [NC];
  logic [IW-1:0] exp_idx;
  logic [DW-1:0] exp_max;

  output_argmax #(.NUM_CLASSES(NC), .DATA_W(DW), .IDX_W(IW)) dut (
    .clk(clk), .rst(rst), .start(start),
    .in_valid(in_valid), .in_ready(in_ready), .in_val(in_val),
    .out_valid(out_valid), .out_ready(out_ready),
    .class_idx(class_idx), .max_val(max_val), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: first occurrence of the largest signed value in the score list.
  function automatic void model();
    exp_idx = '0;
    exp_max = sc[0];
    for (int j = 1; j < NC; j++)
      if ($signed(sc[j]) > $signed(exp_max)) begin
        exp_max = sc[j];
        exp_idx = IW'(j);
      end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_scores(input bit narrow);
    for (int j = 0; j < NC; j++)
      sc[j] = narrow ? DW'($urandom_range(3)) - 8'd2 : DW'($urandom);
  endtask

  // Start an inference and push all NC scores, with optional bubbles and stray starts.
  task automatic feed(input int unsigned bubble_pct, input bit poke_start);
    int i = 0;
    int budget = 0;
    bit acc;
    model();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_after_start", 32'(busy), 32'd1);
    chk("in_ready_collect", 32'(in_ready), 32'd1);
    while (i < NC && budget < 2000) begin
      in_valid = ($urandom_range(99) >= bubble_pct);
      in_val   = in_valid ? sc[i] : DW'($urandom);
      start    = poke_start ? 1'($urandom) : 1'b0;
      acc      = in_valid && in_ready;
      tick();
      budget++;
      if (acc) i++;
      if (i < NC) begin
        chk("no_early_out_valid", 32'(out_valid), 32'd0);
        chk("busy_collect", 32'(busy), 32'd1);
      end
    end
    start    = 1'b0;
    in_valid = 1'b0;
    chk("scores_accepted", 32'(i), 32'(NC));
    chk("out_valid_latency", 32'(out_valid), 32'd1);
    chk("in_ready_done", 32'(in_ready), 32'd0);
    chk("busy_done", 32'(busy), 32'd1);
    chk("class_idx", 32'(class_idx), 32'(exp_idx));
    chk("max_val", 32'(max_val), 32'(exp_max));
  endtask

  // Hold off the result for `stall` cycles, then take it and confirm return to IDLE.
  task automatic drain(input int stall, input bit junk_valid, input bit junk_start);
    out_ready = 1'b0;
    for (int k = 0; k < stall; k++) begin
      in_valid = junk_valid;
      in_val   = DW'($urandom);
      start    = junk_start ? 1'($urandom) : 1'b0;
      tick();
      chk("stall_out_valid", 32'(out_valid), 32'd1);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      chk("stall_class_idx", 32'(class_idx), 32'(exp_idx));
      chk("stall_max_val", 32'(max_val), 32'(exp_max));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    start     = junk_start;
    tick();
    out_ready = 1'b0;
    start     = 1'b0;
    chk("post_hs_out_valid", 32'(out_valid), 32'd0);
    chk("post_hs_busy", 32'(busy), 32'd0);
    chk("retain_class_idx", 32'(class_idx), 32'(exp_idx));
    chk("retain_max_val", 32'(max_val), 32'(exp_max));
    tick();
    chk("idle_after_hs_start", 32'(busy), 32'd0);
    chk("idle_in_ready", 32'(in_ready), 32'd0);
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    in_valid  = 1'b0;
    in_val    = '0;
    out_ready = 1'b0;
    #12;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_class_idx", 32'(class_idx), 32'd0);
    chk("rst_max_val", 32'(max_val), 32'd0);
    rst = 1'b0;
    // in_valid in IDLE must be ignored
    in_valid = 1'b1;
    in_val   = 8'd99;
    tick();
    in_valid = 1'b0;
    chk("idle_ignores_valid", 32'(busy), 32'd0);

    // Basic
    sc = '{8'sd5, -8'sd3, 8'sd12, 8'sd7, 8'sd0, 8'sd1, 8'sd2, 8'sd3, 8'sd4, 8'sd6};
    feed(0, 1'b0);
    chk("basic_idx_is_2", 32'(class_idx), 32'd2);
    drain(0, 1'b0, 1'b0);

    // Signed values and ties
    sc = '{8'sh80, -8'sd5, -8'sd5, -8'sd100, 8'sh80, -8'sd6, -8'sd7, -8'sd9, -8'sd10, -8'sd20};
    feed(0, 1'b0);
    chk("signed_max_fb", 32'(max_val), 32'h0000_00fb);
    drain(3, 1'b0, 1'b0);

    // Winner at the last and the first position
    for (int j = 0; j < NC; j++) sc[j] = 8'd0;
    sc[NC-1] = 8'd127;
    feed(0, 1'b0);
    drain(1, 1'b0, 1'b0);
    for (int j = 0; j < NC; j++) sc[j] = 8'd126;
    sc[0] = 8'd127;
    feed(0, 1'b0);
    drain(1, 1'b0, 1'b0);

    // Bubbles, long stall with junk in_valid and stray starts
    sc = '{8'sd5, -8'sd3, 8'sd12, 8'sd7, 8'sd0, 8'sd1, 8'sd2, 8'sd3, 8'sd4, 8'sd6};
    feed(50, 1'b1);
    drain(20, 1'b1, 1'b1);

    // Asynchronous reset after 4 accepts
    sc[0] = 8'd50;
    start = 1'b1;
    tick();
    start    = 1'b0;
    in_valid = 1'b1;
    for (int j = 0; j < 4; j++) begin
      in_val = sc[j];
      tick();
    end
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_in_ready", 32'(in_ready), 32'd0);
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_class_idx", 32'(class_idx), 32'd0);
    chk("arst_max_val", 32'(max_val), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk("arst_stays_idle", 32'(busy), 32'd0);
    rand_scores(1'b0);
    feed(0, 1'b0);
    drain(2, 1'b0, 1'b0);

    // Randomized inferences
    for (int r = 0; r < 40; r++) begin
      rand_scores(1'($urandom));
      feed($urandom_range(70), 1'($urandom));
      drain(int'($urandom_range(6)), 1'($urandom), 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
